// File: rtl/ysyx_22041211_ifu.sv
// ysyx_22041211_ifu: instruction fetch unit holding the PC, one outstanding fetch, registered output to decode
module ysyx_22041211_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fault_o
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_o_q, pc_o_d, redir_pc;
  logic drop_q, drop_d, fault_q, fault_d, latch;
  logic [31:0] inst_q, inst_d;
  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC[ADDR_W-1:0];
      drop_q  <= 1'b0;
      inst_q  <= '0;
      pc_o_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      pc_o_q  <= pc_o_d;
      fault_q <= fault_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = redirect_valid ? redir_pc : pc_q;
    drop_d  = drop_q;
    case (state_q)
      REQ: begin
        state_d = imem_req_ready ? WAIT : REQ;
        drop_d  = imem_req_ready & redirect_valid;
      end
      WAIT: begin
        state_d = imem_rsp_valid ? ((drop_q | redirect_valid) ? REQ : HOLD) : WAIT;
        drop_d  = imem_rsp_valid ? 1'b0 : (drop_q | redirect_valid);
      end
      HOLD: begin
        state_d = (redirect_valid | out_ready) ? REQ : HOLD;
        pc_d    = redirect_valid ? redir_pc : out_ready ? pc_q + 4 : pc_q;
      end
      default: state_d = REQ;
    endcase
  end
  // Only a live response (no pending or same-cycle redirect) reaches decode
  assign latch   = (state_q == WAIT) & imem_rsp_valid & ~drop_q & ~redirect_valid;
  assign inst_d  = latch ? (imem_rsp_err ? 32'h0000_0013 : imem_rsp_data) : inst_q;
  assign pc_o_d  = latch ? pc_q : pc_o_q;
  assign fault_d = latch ? imem_rsp_err : fault_q;
  assign imem_req_valid = rst_n & (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = state_q == HOLD;
  assign inst_o         = inst_q;
  assign pc_o           = pc_o_q;
  assign fault_o        = fault_q;
endmodule
